// File: rtl/mips_dmem_responder_if.sv
// Request/response bundle between a MIPS core data port and the data-memory responder.
// Latency: none, wires only.
// Backpressure: valid/ready on the request channel and on the response channel.
//
// Signals:
//   req_valid/req_ready   request handshake (initiator -> responder)
//   req_we                1 = store, 0 = load
//   req_addr              byte address
//   req_size              00 byte, 01 half, 10 word, 11 illegal
//   req_wdata             store data, right-justified
//   resp_valid/resp_ready response handshake (responder -> initiator)
//   resp_rdata            load data, right-justified, zero-extended
//   resp_err              access faulted, qualified by resp_valid
interface mips_dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_size, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/mips_dmem_responder.sv
// Data-memory responder for a MIPS core: byte/half/word loads and stores with fault detection.
// Latency: response WAIT_STATES+2 cycles after accept for a legal access, 1 cycle for a fault.
// Backpressure: one access in flight; req_ready only in IDLE, response held until resp_ready.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset (memory contents are kept)
//   bus        request/response channel, slave side
//   err_count  saturating count of faulted accesses
module mips_dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    mips_dmem_responder_if.slave bus,
    output logic [15:0]          err_count
);
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic [3:0]   wait_cnt;

    // Request captured on the accept edge.
    logic          cap_we;
    logic [AW-1:0] cap_idx;
    logic [1:0]    cap_lo;
    logic [1:0]    cap_size;
    logic [31:0]   cap_wdata;

    logic [31:0]  rdata_q;
    logic         err_q;
    logic [15:0]  err_cnt_q;

    logic [31:0]  mem [DEPTH_WORDS];

    logic         accept;
    logic         req_fault;
    logic [4:0]   lane_sh;
    logic [3:0]   lane_be;
    logic [31:0]  rd_mask;
    logic [31:0]  wr_lanes;
    logic [31:0]  rd_word;

    assign bus.req_ready  = (state == IDLE) && !rst;
    assign accept         = bus.req_valid && bus.req_ready;
    assign bus.resp_valid = (state == RESP) && !rst;
    assign bus.resp_rdata = rst ? 32'h0 : rdata_q;
    assign bus.resp_err   = rst ? 1'b0  : err_q;
    assign err_count      = err_cnt_q;

    // Misalignment / illegal size, plus any address past the end of the array.
    always_comb begin
        req_fault = 1'b0;
        case (bus.req_size)
            2'b00:   req_fault = 1'b0;
            2'b01:   req_fault = bus.req_addr[0];
            2'b10:   req_fault = (bus.req_addr[1:0] != 2'b00);
            default: req_fault = 1'b1;
        endcase
        if ({2'b00, bus.req_addr[31:2]} >= 32'(DEPTH_WORDS)) begin
            req_fault = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_fault) begin
                        state_nxt = RESP;
                    end else if (WAIT_STATES == 0) begin
                        state_nxt = ACCESS;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt == 4'd1) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: state_nxt = RESP;
            RESP: begin
                if (bus.resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Little-endian lane selection: shift moves the addressed lane(s) to/from bit 0.
    always_comb begin
        lane_sh = 5'd0;
        lane_be = 4'b1111;
        rd_mask = 32'hFFFF_FFFF;
        case (cap_size)
            2'b00: begin
                lane_sh = {cap_lo, 3'b000};
                lane_be = 4'b0001 << cap_lo;
                rd_mask = 32'h0000_00FF;
            end
            2'b01: begin
                lane_sh = {cap_lo[1], 4'b0000};
                lane_be = cap_lo[1] ? 4'b1100 : 4'b0011;
                rd_mask = 32'h0000_FFFF;
            end
            default: ;
        endcase
    end

    assign wr_lanes = cap_wdata << lane_sh;
    assign rd_word  = (mem[cap_idx] >> lane_sh) & rd_mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt  <= 4'd0;
            cap_we    <= 1'b0;
            cap_idx   <= '0;
            cap_lo    <= 2'b00;
            cap_size  <= 2'b00;
            cap_wdata <= 32'h0;
            rdata_q   <= 32'h0;
            err_q     <= 1'b0;
            err_cnt_q <= 16'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cap_we    <= bus.req_we;
                        cap_idx   <= bus.req_addr[AW+1:2];
                        cap_lo    <= bus.req_addr[1:0];
                        cap_size  <= bus.req_size;
                        cap_wdata <= bus.req_wdata;
                        wait_cnt  <= 4'(WAIT_STATES);
                        rdata_q   <= 32'h0;
                        err_q     <= req_fault;
                        if (req_fault && (err_cnt_q != 16'hFFFF)) begin
                            err_cnt_q <= err_cnt_q + 16'd1;
                        end
                    end
                end
                WAIT: wait_cnt <= wait_cnt - 4'd1;
                ACCESS: begin
                    rdata_q <= cap_we ? 32'h0 : rd_word;
                    err_q   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Array is deliberately not reset; a reset during ACCESS suppresses the store.
    always_ff @(posedge clk) begin
        if (!rst && (state == ACCESS) && cap_we) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_be[i]) begin
                    mem[cap_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_mips_dmem_responder.sv
// Bench for mips_dmem_responder: scoreboard of expected responses, one task per scenario.
// Latency: checks resp_valid arrival cycle relative to the accept cycle.
// Backpressure: exercises resp_ready held low while a new request is presented.
`timescale 1ns/1ps
module tb_mips_dmem_responder;
    localparam int DEPTH = 256;
    localparam int WS    = 2;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] err_count;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] exp_errs = 16'h0;
    exp_t        sb[$];

    mips_dmem_responder_if bus();

    mips_dmem_responder #(
        .DEPTH_WORDS(DEPTH),
        .WAIT_STATES(WS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .err_count (err_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request, wait for acceptance, push its expected response.
    task automatic send(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic [31:0] wdata, input logic [31:0] e_rdata,
                        input logic e_err, input int e_lat);
        int n = 0;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_size  = size;
        bus.req_wdata = wdata;
        bus.req_valid = 1'b1;
        while (!bus.req_ready && n < 50) begin
            step();
            n++;
        end
        if (!bus.req_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout addr=%h: req_ready=%b, required 1", addr, bus.req_ready);
        end
        acc_cyc = cyc;
        sb.push_back('{e_rdata, e_err, e_lat});
        step();
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int lat);
        int n = 0;
        while (!bus.resp_valid && n < 40) begin
            step();
            n++;
        end
        lat = cyc - acc_cyc;
        if (!bus.resp_valid) begin
            n_vec++;
            n_err++;
            $display("FAIL resp_timeout: resp_valid=%b after 40 cycles, required 1", bus.resp_valid);
        end
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b0;
        bus.req_we = 1'b0;
        bus.req_addr = 32'h0;
        bus.req_size = 2'b10;
        bus.req_wdata = 32'h0;
        bus.resp_ready = 1'b1;
        rst = 1'b1;
        step();
        step();
        n_vec++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL rst_req_ready: got %b, required 0", bus.req_ready); end
        n_vec++; if (bus.resp_valid !== 1'b0) begin n_err++; $display("FAIL rst_resp_valid: got %b, required 0", bus.resp_valid); end
        n_vec++; if (bus.resp_err !== 1'b0) begin n_err++; $display("FAIL rst_resp_err: got %b, required 0", bus.resp_err); end
        n_vec++; if (bus.resp_rdata !== 32'h0) begin n_err++; $display("FAIL rst_resp_rdata: got %h, required 0", bus.resp_rdata); end
        n_vec++; if (err_count !== 16'h0) begin n_err++; $display("FAIL rst_err_count: got %h, required 0", err_count); end
        rst = 1'b0;
        #1;
        n_vec++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_req_ready: got %b, required 1", bus.req_ready); end
        exp_errs = 16'h0;
    endtask

    task automatic test_word_rw();
        vec_t tbl[$];
        int   lat;
        exp_t e;
        tbl.push_back('{1'b1, 32'h10, 2'b10, 32'hDEADBEEF, 32'h0,        1'b0});
        tbl.push_back('{1'b0, 32'h10, 2'b10, 32'h0,        32'hDEADBEEF, 1'b0});
        foreach (tbl[i]) begin
            send(tbl[i].we, tbl[i].addr, tbl[i].size, tbl[i].wdata, tbl[i].rdata, tbl[i].err,
                 tbl[i].err ? 1 : WS + 2);
            wait_resp(lat);
            e = sb.pop_front();
            n_vec++;
            if (bus.resp_rdata !== e.rdata || bus.resp_err !== e.err || lat != e.lat) begin
                n_err++;
                $display("FAIL word_rw[%0d]: rdata=%h err=%b lat=%0d, required rdata=%h err=%b lat=%0d",
                         i, bus.resp_rdata, bus.resp_err, lat, e.rdata, e.err, e.lat);
            end
            step();
        end
    endtask

    task automatic test_lanes();
        vec_t tbl[$];
        int   lat;
        exp_t e;
        tbl.push_back('{1'b1, 32'h20, 2'b10, 32'h11223344, 32'h0,        1'b0});
        tbl.push_back('{1'b1, 32'h21, 2'b00, 32'h123456AA, 32'h0,        1'b0});
        tbl.push_back('{1'b0, 32'h20, 2'b10, 32'h0,        32'h1122AA44, 1'b0});
        tbl.push_back('{1'b0, 32'h22, 2'b01, 32'h0,        32'h00001122, 1'b0});
        tbl.push_back('{1'b0, 32'h21, 2'b00, 32'h0,        32'h000000AA, 1'b0});
        tbl.push_back('{1'b1, 32'h22, 2'b01, 32'hFFFF5566, 32'h0,        1'b0});
        tbl.push_back('{1'b0, 32'h20, 2'b10, 32'h0,        32'h5566AA44, 1'b0});
        tbl.push_back('{1'b0, 32'h20, 2'b01, 32'h0,        32'h0000AA44, 1'b0});
        tbl.push_back('{1'b0, 32'h23, 2'b00, 32'h0,        32'h00000055, 1'b0});
        tbl.push_back('{1'b1, 32'h20, 2'b00, 32'h000000C3, 32'h0,        1'b0});
        tbl.push_back('{1'b0, 32'h20, 2'b10, 32'h0,        32'h5566AAC3, 1'b0});
        foreach (tbl[i]) begin
            send(tbl[i].we, tbl[i].addr, tbl[i].size, tbl[i].wdata, tbl[i].rdata, tbl[i].err,
                 tbl[i].err ? 1 : WS + 2);
            wait_resp(lat);
            e = sb.pop_front();
            n_vec++;
            if (bus.resp_rdata !== e.rdata || bus.resp_err !== e.err || lat != e.lat) begin
                n_err++;
                $display("FAIL lanes[%0d]: rdata=%h err=%b lat=%0d, required rdata=%h err=%b lat=%0d",
                         i, bus.resp_rdata, bus.resp_err, lat, e.rdata, e.err, e.lat);
            end
            step();
        end
    endtask

    task automatic test_faults();
        vec_t tbl[$];
        int   lat;
        exp_t e;
        tbl.push_back('{1'b1, 32'h00,  2'b10, 32'hCAFEF00D, 32'h0,        1'b0});
        tbl.push_back('{1'b0, 32'h22,  2'b10, 32'h0,        32'h0,        1'b1});
        tbl.push_back('{1'b1, 32'h400, 2'b10, 32'h0BADBAD0, 32'h0,        1'b1});
        tbl.push_back('{1'b0, 32'h00,  2'b10, 32'h0,        32'hCAFEF00D, 1'b0});
        tbl.push_back('{1'b0, 32'h11,  2'b01, 32'h0,        32'h0,        1'b1});
        tbl.push_back('{1'b0, 32'h10,  2'b11, 32'h0,        32'h0,        1'b1});
        tbl.push_back('{1'b1, 32'h401, 2'b00, 32'h000000EE, 32'h0,        1'b1});
        tbl.push_back('{1'b1, 32'h3FC, 2'b10, 32'h13579BDF, 32'h0,        1'b0});
        tbl.push_back('{1'b0, 32'h3FC, 2'b10, 32'h0,        32'h13579BDF, 1'b0});
        tbl.push_back('{1'b0, 32'h00,  2'b10, 32'h0,        32'hCAFEF00D, 1'b0});
        foreach (tbl[i]) begin
            send(tbl[i].we, tbl[i].addr, tbl[i].size, tbl[i].wdata, tbl[i].rdata, tbl[i].err,
                 tbl[i].err ? 1 : WS + 2);
            if (tbl[i].err && exp_errs != 16'hFFFF) exp_errs = exp_errs + 16'd1;
            wait_resp(lat);
            e = sb.pop_front();
            n_vec++;
            if (bus.resp_rdata !== e.rdata || bus.resp_err !== e.err || lat != e.lat) begin
                n_err++;
                $display("FAIL faults[%0d]: rdata=%h err=%b lat=%0d, required rdata=%h err=%b lat=%0d",
                         i, bus.resp_rdata, bus.resp_err, lat, e.rdata, e.err, e.lat);
            end
            n_vec++;
            if (err_count !== exp_errs) begin
                n_err++;
                $display("FAIL faults_err_count[%0d]: got %h, required %h", i, err_count, exp_errs);
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        int   lat;
        exp_t e;
        bus.resp_ready = 1'b0;
        send(1'b0, 32'h10, 2'b10, 32'h0, 32'hDEADBEEF, 1'b0, WS + 2);
        wait_resp(lat);
        e = sb.pop_front();
        n_vec++;
        if (bus.resp_rdata !== e.rdata || bus.resp_err !== e.err || lat != e.lat) begin
            n_err++;
            $display("FAIL bp_first: rdata=%h err=%b lat=%0d, required rdata=%h err=%b lat=%0d",
                     bus.resp_rdata, bus.resp_err, lat, e.rdata, e.err, e.lat);
        end
        // A second request is offered while the response is stalled.
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h20;
        bus.req_size  = 2'b10;
        bus.req_wdata = 32'h0;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            n_vec++;
            if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'hDEADBEEF ||
                bus.resp_err !== 1'b0 || bus.req_ready !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: valid=%b rdata=%h err=%b req_ready=%b, required 1 deadbeef 0 0",
                         i, bus.resp_valid, bus.resp_rdata, bus.resp_err, bus.req_ready);
            end
        end
        bus.resp_ready = 1'b1;
        step();
        n_vec++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_release: valid=%b req_ready=%b, required 0 1", bus.resp_valid, bus.req_ready);
        end
        acc_cyc = cyc;
        sb.push_back('{32'h5566AAC3, 1'b0, WS + 2});
        step();
        bus.req_valid = 1'b0;
        wait_resp(lat);
        e = sb.pop_front();
        n_vec++;
        if (bus.resp_rdata !== e.rdata || bus.resp_err !== e.err || lat != e.lat) begin
            n_err++;
            $display("FAIL bp_held_req: rdata=%h err=%b lat=%0d, required rdata=%h err=%b lat=%0d",
                     bus.resp_rdata, bus.resp_err, lat, e.rdata, e.err, e.lat);
        end
        step();
    endtask

    task automatic test_reset_midop();
        int   lat;
        exp_t e;
        bit   saw_resp = 1'b0;
        send(1'b1, 32'h30, 2'b10, 32'h0, 32'h0, 1'b0, WS + 2);
        wait_resp(lat);
        e = sb.pop_front();
        step();
        bus.req_we    = 1'b1;
        bus.req_addr  = 32'h30;
        bus.req_size  = 2'b00;
        bus.req_wdata = 32'h00000055;
        bus.req_valid = 1'b1;
        n_vec++;
        if (bus.req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL midop_accept: req_ready=%b, required 1", bus.req_ready);
        end
        step();
        bus.req_valid = 1'b0;
        rst = 1'b1;
        step();
        n_vec++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL midop_in_rst: valid=%b req_ready=%b, required 0 0", bus.resp_valid, bus.req_ready);
        end
        rst = 1'b0;
        exp_errs = 16'h0;
        for (int i = 0; i < 10; i++) begin
            if (bus.resp_valid) saw_resp = 1'b1;
            step();
        end
        n_vec++;
        if (saw_resp !== 1'b0) begin
            n_err++;
            $display("FAIL midop_no_resp: saw resp_valid=%b, required 0", saw_resp);
        end
        n_vec++;
        if (err_count !== exp_errs) begin
            n_err++;
            $display("FAIL midop_err_count: got %h, required %h", err_count, exp_errs);
        end
        send(1'b0, 32'h30, 2'b10, 32'h0, 32'h0, 1'b0, WS + 2);
        wait_resp(lat);
        e = sb.pop_front();
        n_vec++;
        if (bus.resp_rdata !== e.rdata || bus.resp_err !== e.err || lat != e.lat) begin
            n_err++;
            $display("FAIL midop_load: rdata=%h err=%b lat=%0d, required rdata=%h err=%b lat=%0d",
                     bus.resp_rdata, bus.resp_err, lat, e.rdata, e.err, e.lat);
        end
        step();
    endtask

    task automatic test_saturation();
        int   lat;
        exp_t e;
        for (int i = 0; i < 7; i++) begin
            if (i == 3) begin
                // Jump the counter close to its ceiling instead of issuing 65k faults.
                force dut.err_cnt_q = 16'hFFFD;
                #1;
                release dut.err_cnt_q;
                exp_errs = 16'hFFFD;
            end
            send(1'b0, 32'(i * 4), 2'b11, 32'h0, 32'h0, 1'b1, 1);
            if (exp_errs != 16'hFFFF) exp_errs = exp_errs + 16'd1;
            wait_resp(lat);
            e = sb.pop_front();
            n_vec++;
            if (bus.resp_rdata !== e.rdata || bus.resp_err !== e.err || lat != e.lat) begin
                n_err++;
                $display("FAIL sat_resp[%0d]: rdata=%h err=%b lat=%0d, required rdata=%h err=%b lat=%0d",
                         i, bus.resp_rdata, bus.resp_err, lat, e.rdata, e.err, e.lat);
            end
            n_vec++;
            if (err_count !== exp_errs) begin
                n_err++;
                $display("FAIL sat_err_count[%0d]: got %h, required %h", i, err_count, exp_errs);
            end
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_word_rw();
        test_lanes();
        test_faults();
        test_backpressure();
        test_reset_midop();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mips_dmem_responder.md
MIPS_DMEM_RESPONDER -- requirements
Module: mips_dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 256, giving memory depth in 32-bit words.
REQ-002 The block SHALL have parameter WAIT_STATES, default 2, giving extra wait cycles per access (range 0-15).
REQ-003 The block SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 The block SHALL have port req_valid, input, 1, initiator presents a request.
REQ-006 The block SHALL have port req_ready, output, 1, responder can accept a request.
REQ-007 The block SHALL have port req_we, input, 1, 1 = store, 0 = load.
REQ-008 The block SHALL have port req_addr, input, 32, byte address.
REQ-009 The block SHALL have port req_size, input, 2, access size: 00 byte, 01 half, 10 word, 11 illegal.
REQ-010 The block SHALL have port req_wdata, input, 32, store data, right-justified.
REQ-011 The block SHALL have port resp_valid, output, 1, response available.
REQ-012 The block SHALL have port resp_ready, input, 1, initiator accepts the response.
REQ-013 The block SHALL have port resp_rdata, output, 32, load data, right-justified and zero-extended.
REQ-014 The block SHALL have port resp_err, output, 1, access faulted; qualified by resp_valid.
REQ-015 The block SHALL have port err_count, output, 16, count of faulted accesses, saturating.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT, ACCESS and RESP; req_ready = 1 only in IDLE.
REQ-017 A request SHALL be accepted on a cycle with req_valid & req_ready; we, addr, size and wdata are captured on that edge.
REQ-018 Fault conditions SHALL be: size 11; half with addr[0] = 1; word with addr[1:0] != 00; word index addr[31:2] >= DEPTH_WORDS.
REQ-019 On accept, a faulted request SHALL go IDLE->RESP with resp_err = 1 and resp_rdata = 0, and memory is left untouched.
REQ-020 On accept, a legal request SHALL go to WAIT with the wait counter loaded to WAIT_STATES, or directly to ACCESS if WAIT_STATES = 0.
REQ-021 WAIT SHALL decrement the counter each cycle and move to ACCESS on the cycle the counter equals 1.
REQ-022 ACCESS SHALL last one cycle and perform the read or write.
REQ-023 Latency: with the accept in cycle 0, resp_valid SHALL first be high in cycle WAIT_STATES+2 for a legal access and cycle 1 for a fault.
REQ-024 Writes SHALL be little-endian with byte lanes.
  - Byte: writes wdata[7:0] to lane addr[1:0].
  - Half: writes wdata[15:0] to lanes {addr[1],0} and {addr[1],1}.
  - Word: writes all four lanes.
  - Other lanes are unchanged.
REQ-025 Reads SHALL return the selected lane(s) right-justified and zero-extended; sign extension is the initiator's job. A write response SHALL carry resp_rdata = 0.
REQ-026 In RESP, resp_valid, resp_rdata and resp_err SHALL be held stable until resp_ready = 1; the FSM moves to IDLE on the edge where both are high.
REQ-027 After a response handshake, the next request SHALL be acceptable at the earliest one cycle later, since IDLE is re-entered.
REQ-028 err_count SHALL increment by 1 on each faulted accept and saturate at 16'hFFFF.
REQ-029 Requests arriving outside IDLE SHALL be ignored; the initiator holds req_valid and its request fields until accepted.

Reset
REQ-030 While rst = 1, the block SHALL set:
  - state = IDLE and wait counter = 0.
  - resp_valid = 0, resp_err = 0, resp_rdata = 0, err_count = 0.
  - req_ready = 0 during the reset cycle and 1 on the first cycle after rst deasserts.
REQ-031 Reset in WAIT or RESP SHALL discard the pending access. A write that has not reached ACCESS is not performed, and no response is issued.
REQ-032 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-033 Word store then load, WAIT_STATES = 2: store addr 0x10, data 0xDEADBEEF, then load addr 0x10 -> rdata 0xDEADBEEF, err 0, resp_valid in cycle 4 after accept.
REQ-034 Byte and half lanes: word 0x11223344 at 0x20.
  - Store byte 0xAA to 0x21 -> load word 0x1122AA44.
  - Load half 0x22 -> 0x00001122.
  - Load byte 0x21 -> 0x000000AA.
REQ-035 Faults:
  - Word load at 0x22 -> resp_valid in cycle 1, err 1, rdata 0, err_count 1.
  - Store to word index DEPTH_WORDS -> err 1, err_count 2, memory unchanged.
REQ-036 Backpressure: hold resp_ready = 0 for 5 cycles in RESP -> outputs stable, req_ready 0, new req_valid ignored; handshake -> IDLE next cycle.
REQ-037 Reset mid-op: accept store 0x55 to 0x30 (old value 0), assert rst in WAIT -> no response; load 0x30 -> 0x00000000.
REQ-038 Counter saturation: force 65537 faulted accesses -> err_count holds 16'hFFFF.
